// File: rtl/bird_pkg.sv
// Shared definitions for the bird motion engine and the display stage:
// game-life state encoding, fixed-point precision and playfield geometry.
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        DEAD   = 2'd2
    } bird_state_t;

    localparam int FRAC_BITS     = 4;
    localparam int SCREEN_HEIGHT = 480;
    localparam int BIRD_HEIGHT   = 35;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: one-cycle pulse when the level goes from 0 to 1,
// based on the level seen on the previous clock.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/bird_physics.sv
// Per-frame vertical motion of the player sprite: gravity/flap integration in
// Q.4 fixed point, ceiling/floor clamping and the idle/flying/dead life cycle.
module bird_physics
    import bird_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        flap,
    input  logic        collision,
    input  logic        restart,
    output logic [31:0] bird_reg,
    output logic [1:0]  bird_state,
    output logic        dead_pulse
);

    localparam int                 START_Y           = 200;
    localparam logic signed [11:0] GRAVITY           = 12'sd3;
    localparam logic signed [10:0] FLAP_VELOCITY     = -11'sd40;
    localparam logic signed [11:0] MAX_FALL_VELOCITY = 12'sd64;
    localparam logic signed [14:0] START_POS = 15'(START_Y << FRAC_BITS);
    localparam logic signed [15:0] FLOOR_POS =
        16'((SCREEN_HEIGHT - 1 - BIRD_HEIGHT) << FRAC_BITS);

    bird_state_t        r_state, w_state_n;
    logic signed [14:0] r_pos, w_pos_n;
    logic signed [10:0] r_vel, w_vel_next;
    logic               r_pending, w_pending_n;
    logic               r_dead_pulse, w_dead_pulse_n;

    logic               w_flap_rise;
    logic signed [11:0] w_vel_grav;
    logic signed [10:0] w_vel_n;
    logic signed [15:0] w_pos_sum;

    edge_detect u_flap_edge (
        .clk     (clk),
        .reset   (reset),
        .i_level (flap),
        .o_rise  (w_flap_rise)
    );

    // A flap edge arriving on the tick cycle itself is consumed by that tick.
    assign w_vel_grav = {r_vel[10], r_vel} + GRAVITY;
    assign w_vel_n    = (r_pending | w_flap_rise) ? FLAP_VELOCITY :
                        (w_vel_grav > MAX_FALL_VELOCITY) ? MAX_FALL_VELOCITY[10:0] :
                        w_vel_grav[10:0];
    assign w_pos_sum  = {r_pos[14], r_pos} + {{5{w_vel_n[10]}}, w_vel_n};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pos        <= START_POS;
            r_vel        <= '0;
            r_pending    <= 1'b0;
            r_dead_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pos        <= w_pos_n;
            r_vel        <= w_vel_next;
            r_pending    <= w_pending_n;
            r_dead_pulse <= w_dead_pulse_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_pos_n        = r_pos;
        w_vel_next     = r_vel;
        w_pending_n    = r_pending;
        w_dead_pulse_n = 1'b0;
        if (restart) begin
            w_state_n   = IDLE;
            w_pos_n     = START_POS;
            w_vel_next  = '0;
            w_pending_n = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_pos_n    = START_POS;
                    w_vel_next = '0;
                    if (w_flap_rise) begin
                        w_state_n   = FLYING;
                        w_pending_n = 1'b1;
                    end
                end
                FLYING: begin
                    // Collision beats a coincident tick: the bird freezes in place.
                    if (collision) begin
                        w_state_n      = DEAD;
                        w_dead_pulse_n = 1'b1;
                    end else begin
                        if (w_flap_rise) begin
                            w_pending_n = 1'b1;
                        end
                        if (frame_tick) begin
                            w_pending_n = 1'b0;
                            if (w_pos_sum <= 16'sd0) begin
                                w_pos_n    = '0;
                                w_vel_next = '0;
                            end else if (w_pos_sum >= FLOOR_POS) begin
                                w_pos_n        = FLOOR_POS[14:0];
                                w_vel_next     = '0;
                                w_state_n      = DEAD;
                                w_dead_pulse_n = 1'b1;
                            end else begin
                                w_pos_n    = w_pos_sum[14:0];
                                w_vel_next = w_vel_n;
                            end
                        end
                    end
                end
                DEAD: begin
                end
                default: begin
                    w_state_n = IDLE;
                end
            endcase
        end
    end

    assign bird_reg   = {23'b0, r_pos[FRAC_BITS+8:FRAC_BITS]};
    assign bird_state = r_state;
    assign dead_pulse = r_dead_pulse;

endmodule

// File: tb/tb_bird_physics.sv
// Self-checking bench for bird_physics: directed scenarios plus random
// stimulus, compared every cycle against an integer reference model.
module tb_bird_physics;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic        flap;
    logic        collision;
    logic        restart;
    logic [31:0] bird_reg;
    logic [1:0]  bird_state;
    logic        dead_pulse;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: position/velocity as plain integers in 1/16 px.
    int mPos     = 3200;
    int mVel     = 0;
    int mState   = 0;
    bit mPending = 0;
    bit mPrev    = 0;
    bit mPulse   = 0;

    bird_physics dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .flap       (flap),
        .collision  (collision),
        .restart    (restart),
        .bird_reg   (bird_reg),
        .bird_state (bird_state),
        .dead_pulse (dead_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit rst, input bit tick, input bit flp,
                             input bit coll, input bit rs);
        bit rise;
        int v;
        int p;
        rise   = flp && !mPrev;
        mPulse = 0;
        if (rst) begin
            mPos = 3200; mVel = 0; mState = 0; mPending = 0; mPrev = 0;
            return;
        end
        mPrev = flp;
        if (rs) begin
            mPos = 3200; mVel = 0; mState = 0; mPending = 0;
        end else if (mState == 0) begin
            if (rise) begin
                mState = 1; mPending = 1;
            end
        end else if (mState == 1) begin
            if (coll) begin
                mState = 2; mPulse = 1;
            end else begin
                if (rise) mPending = 1;
                if (tick) begin
                    v = mPending ? -40 : ((mVel + 3 > 64) ? 64 : mVel + 3);
                    p = mPos + v;
                    mPending = 0;
                    if (p <= 0) begin
                        mPos = 0; mVel = 0;
                    end else if (p >= 444 * 16) begin
                        mPos = 444 * 16; mVel = 0; mState = 2; mPulse = 1;
                    end else begin
                        mPos = p; mVel = v;
                    end
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic applyStimulus(input bit rst, input bit tick, input bit flp,
                                 input bit coll, input bit rs);
        reset      = rst;
        frame_tick = tick;
        flap       = flp;
        collision  = coll;
        restart    = rs;
        modelStep(rst, tick, flp, coll, rs);
        @(posedge clk);
        #1;
        checkOutput("birdReg", int'(bird_reg), mPos / 16);
        checkOutput("birdState", int'(bird_state), mState);
        checkOutput("deadPulse", int'(dead_pulse), int'(mPulse));
    endtask

    task automatic runFrame(input bit doFlap);
        if (doFlap) begin
            applyStimulus(0, 0, 1, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        int held;
        int pulses;
        reset = 1; frame_tick = 0; flap = 0; collision = 0; restart = 0;

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("resetReg", int'(bird_reg), 200);
        checkOutput("resetState", int'(bird_state), 0);
        checkOutput("resetPulse", int'(dead_pulse), 0);

        $display("[TB] idle hold");
        for (int i = 0; i < 10; i++) runFrame(0);
        checkOutput("idleHold", int'(bird_reg), 200);

        $display("[TB] first flap");
        runFrame(1);
        checkOutput("firstFlap", int'(bird_reg), 197);
        checkOutput("firstFlapState", int'(bird_state), 1);
        runFrame(0);
        checkOutput("secondTick", int'(bird_reg), 195);

        $display("[TB] ceiling");
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 80; i++) runFrame(1);
        checkOutput("ceilingReg", int'(bird_reg), 0);
        checkOutput("ceilingState", int'(bird_state), 1);
        runFrame(0);
        checkOutput("ceilingFall", int'(bird_reg), 0);

        $display("[TB] flap coincident with tick");
        applyStimulus(0, 0, 0, 0, 1);
        runFrame(1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("coincidentFlap", int'(bird_reg), 195);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] free fall to floor");
        applyStimulus(0, 0, 0, 0, 1);
        runFrame(1);
        n = 0;
        pulses = 0;
        while (int'(bird_state) != 2 && n < 200) begin
            applyStimulus(0, 1, 0, 0, 0);
            if (dead_pulse) pulses++;
            applyStimulus(0, 0, 0, 0, 0);
            if (dead_pulse) pulses++;
            n++;
        end
        checkOutput("floorReached", int'(n < 200), 1);
        checkOutput("floorReg", int'(bird_reg), 444);
        checkOutput("floorState", int'(bird_state), 2);
        checkOutput("floorPulseCount", pulses, 1);
        for (int i = 0; i < 4; i++) runFrame(1);
        checkOutput("deadHold", int'(bird_reg), 444);
        checkOutput("deadHoldState", int'(bird_state), 2);

        $display("[TB] collision priority and restart");
        applyStimulus(0, 0, 0, 0, 1);
        runFrame(1);
        runFrame(0);
        held = int'(bird_reg);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("collisionState", int'(bird_state), 2);
        checkOutput("collisionFreeze", int'(bird_reg), held);
        checkOutput("collisionPulse", int'(dead_pulse), 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("restartReg", int'(bird_reg), 200);
        checkOutput("restartState", int'(bird_state), 0);
        runFrame(0);
        checkOutput("noStaleFlap", int'(bird_state), 0);
        checkOutput("noStaleFlapReg", int'(bird_reg), 200);

        $display("[TB] random");
        for (int i = 0; i < 3000; i++) begin
            bit rTick;
            bit rFlap;
            bit rColl;
            bit rRs;
            bit rRst;
            rTick = ($urandom_range(0, 5) == 0);
            rFlap = (i % 7 < 3) ? ($urandom_range(0, 1) == 1) : flap;
            rColl = ($urandom_range(0, 99) == 0);
            rRs   = ($urandom_range(0, 149) == 0);
            rRst  = ($urandom_range(0, 999) == 0);
            applyStimulus(rRst, rTick, rFlap, rColl, rRs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
